// File: rtl/load_responder_pkg.sv
// Shared OOO definitions: RS tags, load sizes and load-FSM state.
// Consumed by load_responder and load_align.
package load_responder_pkg;

  typedef logic [3:0] RS_tag_type;
  localparam RS_tag_type INVALID = 4'h0;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } load_state_e;

  // Size code 3 has no meaning of its own and behaves as a word.
  function automatic mem_size_e to_mem_size(input logic [1:0] sz);
    case (sz)
      2'd0:    return BYTE;
      2'd1:    return HALF;
      default: return WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension (purely combinational).
module load_align
  import load_responder_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  mem_size_e   size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (addr_lo)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
    endcase
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // sign=1 means unsigned load, so the fill bit is zero.
  always_comb begin
    data = rdata;
    unique case (1'b1)
      (size == BYTE): data = {{24{~sign & b[7]}}, b};
      (size == HALF): data = {{16{~sign & h[15]}}, h};
      default:        data = rdata;
    endcase
  end

endmodule

// File: rtl/load_responder.sv
// Data-BRAM load responder: accept, read, align, hold for CDB grant.
// Optional LOAD_RESP_MISALIGN_CHECK_EN flags misaligned half/word loads.
module load_responder
  import load_responder_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MEM_READ,
  input  logic [31:0]       MEM_ADDR2,
  input  logic [1:0]        MEM_SIZE,
  input  logic              MEM_SIGN,
  input  RS_tag_type        req_tag,
  input  logic              flush,
  input  logic              cdb_grant,
  output logic              mem_resp,
  output logic              mem_resp_valid,
  output logic [31:0]       mem_data_out,
  output RS_tag_type        resp_tag,
  output logic              dmem_en,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_rdata,
  output logic              resp_misalign
);

  load_state_e state, state_nxt;
  mem_size_e   size_in, size_q;
  logic        accept, misalign;
  logic [1:0]  lo_q;
  logic        sign_q, mis_q;
  RS_tag_type  tag_q;
  logic [31:0] data_q, aligned;
  logic        unused_hi;

  assign size_in   = to_mem_size(MEM_SIZE);
  assign unused_hi = ^MEM_ADDR2[31:ADDR_W+2];

`ifdef LOAD_RESP_MISALIGN_CHECK_EN
  assign misalign = ((size_in == HALF) && MEM_ADDR2[0]) ||
                    ((size_in == WORD) && (MEM_ADDR2[1:0] != 2'd0));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    accept = 1'b0;
    unique case (state)
      IDLE:    accept = MEM_READ & ~flush;
      RESP:    accept = cdb_grant & MEM_READ & ~flush;
      default: accept = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RD;
      RD:   state_nxt = flush ? IDLE : RESP;
      RESP: begin
        if (flush)          state_nxt = IDLE;
        else if (cdb_grant) state_nxt = accept ? RD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lo_q   <= 2'd0;
      size_q <= WORD;
      sign_q <= 1'b0;
      mis_q  <= 1'b0;
      tag_q  <= INVALID;
      data_q <= 32'd0;
    end else begin
      if (accept) begin
        lo_q   <= MEM_ADDR2[1:0];
        size_q <= size_in;
        sign_q <= MEM_SIGN;
        mis_q  <= misalign;
        tag_q  <= req_tag;
      end
      if (state == RD) data_q <= mis_q ? 32'd0 : aligned;
    end
  end

  load_align u_align (
    .rdata   (dmem_rdata),
    .addr_lo (lo_q),
    .size    (size_q),
    .sign    (sign_q),
    .data    (aligned)
  );

  always_comb begin
    mem_resp       = accept;
    dmem_en        = accept & ~misalign & ~RST;
    dmem_addr      = dmem_en ? MEM_ADDR2[ADDR_W+1:2] : '0;
    mem_resp_valid = (state == RESP);
    mem_data_out   = mem_resp_valid ? data_q : 32'd0;
    resp_tag       = mem_resp_valid ? tag_q : INVALID;
    resp_misalign  = mem_resp_valid & mis_q;
  end

endmodule

// File: tb/tb_load_responder.sv
// Directed bench for load_responder with a 1-cycle BRAM model.
// Expected values follow LOAD_RESP_MISALIGN_CHECK_EN when defined.
module tb_load_responder;
  import load_responder_pkg::*;

  logic        CLK, RST;
  logic        MEM_READ, MEM_SIGN, flush, cdb_grant;
  logic [31:0] MEM_ADDR2;
  logic [1:0]  MEM_SIZE;
  RS_tag_type  req_tag, resp_tag;
  logic        mem_resp, mem_resp_valid, dmem_en, resp_misalign;
  logic [31:0] mem_data_out, dmem_rdata;
  logic [13:0] dmem_addr;

  logic [31:0] mem [0:16383];
  int n_vec = 0;
  int n_err = 0;

  load_responder #(.ADDR_W(14)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .MEM_READ       (MEM_READ),
    .MEM_ADDR2      (MEM_ADDR2),
    .MEM_SIZE       (MEM_SIZE),
    .MEM_SIGN       (MEM_SIGN),
    .req_tag        (req_tag),
    .flush          (flush),
    .cdb_grant      (cdb_grant),
    .mem_resp       (mem_resp),
    .mem_resp_valid (mem_resp_valid),
    .mem_data_out   (mem_data_out),
    .resp_tag       (resp_tag),
    .dmem_en        (dmem_en),
    .dmem_addr      (dmem_addr),
    .dmem_rdata     (dmem_rdata),
    .resp_misalign  (resp_misalign)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (dmem_en) dmem_rdata <= mem[dmem_addr];

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic run_load(input string nm, input logic [31:0] addr,
                          input logic [1:0] sz, input logic sg,
                          input RS_tag_type tg, input logic [31:0] exp_d,
                          input logic exp_mis);
    logic [31:0] wa;
    MEM_READ  = 1'b1;
    MEM_ADDR2 = addr;
    MEM_SIZE  = sz;
    MEM_SIGN  = sg;
    req_tag   = tg;
    #1;
    chk({nm, "/mem_resp"}, {31'd0, mem_resp}, 32'd1);
    chk({nm, "/dmem_en"}, {31'd0, dmem_en}, {31'd0, ~exp_mis});
    wa = {18'd0, addr[15:2]};
    if (!exp_mis) chk({nm, "/dmem_addr"}, {18'd0, dmem_addr}, wa);
    @(posedge CLK); #1;
    MEM_READ = 1'b0;
    chk({nm, "/rd_valid"}, {31'd0, mem_resp_valid}, 32'd0);
    @(posedge CLK); #1;
    chk({nm, "/valid"}, {31'd0, mem_resp_valid}, 32'd1);
    chk({nm, "/data"}, mem_data_out, exp_d);
    chk({nm, "/tag"}, {28'd0, resp_tag}, {28'd0, tg});
    chk({nm, "/misalign"}, {31'd0, resp_misalign}, {31'd0, exp_mis});
  endtask

  task automatic grant_release(input string nm);
    cdb_grant = 1'b1;
    @(posedge CLK); #1;
    cdb_grant = 1'b0;
    chk({nm, "/idle_valid"}, {31'd0, mem_resp_valid}, 32'd0);
    chk({nm, "/idle_tag"}, {28'd0, resp_tag}, {28'd0, INVALID});
    chk({nm, "/idle_data"}, mem_data_out, 32'd0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "/valid"}, {31'd0, mem_resp_valid}, 32'd0);
    chk({nm, "/data"}, mem_data_out, 32'd0);
    chk({nm, "/tag"}, {28'd0, resp_tag}, {28'd0, INVALID});
    chk({nm, "/dmem_en"}, {31'd0, dmem_en}, 32'd0);
    chk({nm, "/dmem_addr"}, {18'd0, dmem_addr}, 32'd0);
    chk({nm, "/misalign"}, {31'd0, resp_misalign}, 32'd0);
  endtask

  initial begin
    mem[14'h40] = 32'hDEADBEEF;
    mem[14'h41] = 32'h12345678;
    RST = 1'b1; MEM_READ = 1'b0; MEM_ADDR2 = 32'd0; MEM_SIZE = 2'd0;
    MEM_SIGN = 1'b0; req_tag = INVALID; flush = 1'b0; cdb_grant = 1'b0;
    #3;
    chk_reset_outs("reset");
    #9 RST = 1'b0;
    @(posedge CLK); #1;

    run_load("word", 32'h100, 2'd2, 1'b0, 4'd3, 32'hDEADBEEF, 1'b0);
    grant_release("word");
    run_load("byte_s", 32'h103, 2'd0, 1'b0, 4'd1, 32'hFFFFFFDE, 1'b0);
    grant_release("byte_s");
    run_load("byte_u", 32'h103, 2'd0, 1'b1, 4'd2, 32'h000000DE, 1'b0);
    grant_release("byte_u");
    run_load("byte0", 32'h100, 2'd0, 1'b0, 4'd4, 32'hFFFFFFEF, 1'b0);
    grant_release("byte0");
    run_load("half_s", 32'h102, 2'd1, 1'b0, 4'd5, 32'hFFFFDEAD, 1'b0);
    grant_release("half_s");
    run_load("half_u", 32'h100, 2'd1, 1'b1, 4'd6, 32'h0000BEEF, 1'b0);
    grant_release("half_u");
    run_load("size3", 32'h104, 2'd3, 1'b0, 4'd8, 32'h12345678, 1'b0);
    grant_release("size3");

    run_load("bp", 32'h104, 2'd2, 1'b0, 4'd5, 32'h12345678, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk("bp/hold_valid", {31'd0, mem_resp_valid}, 32'd1);
      chk("bp/hold_data", mem_data_out, 32'h12345678);
      chk("bp/hold_tag", {28'd0, resp_tag}, 32'd5);
    end
    cdb_grant = 1'b1; MEM_READ = 1'b1; MEM_ADDR2 = 32'h100;
    MEM_SIZE = 2'd2; MEM_SIGN = 1'b0; req_tag = 4'd7;
    #1;
    chk("bp/grant_accept", {31'd0, mem_resp}, 32'd1);
    @(posedge CLK); #1;
    cdb_grant = 1'b0; MEM_READ = 1'b0;
    chk("bp/rd_valid", {31'd0, mem_resp_valid}, 32'd0);
    @(posedge CLK); #1;
    chk("bp/next_valid", {31'd0, mem_resp_valid}, 32'd1);
    chk("bp/next_data", mem_data_out, 32'hDEADBEEF);
    chk("bp/next_tag", {28'd0, resp_tag}, 32'd7);
    grant_release("bp");

    MEM_READ = 1'b1; MEM_ADDR2 = 32'h100; MEM_SIZE = 2'd2; req_tag = 4'd2;
    @(posedge CLK); #1;
    MEM_READ = 1'b0; flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    chk("flush_rd/valid", {31'd0, mem_resp_valid}, 32'd0);
    chk("flush_rd/tag", {28'd0, resp_tag}, {28'd0, INVALID});
    MEM_READ = 1'b1; flush = 1'b1; #1;
    chk("flush_idle/block", {31'd0, mem_resp}, 32'd0);
    flush = 1'b0; #1;
    chk("flush_rd/is_idle", {31'd0, mem_resp}, 32'd1);
    MEM_READ = 1'b0;
    @(posedge CLK); #1;
    chk("flush_rd/no_late", {31'd0, mem_resp_valid}, 32'd0);

    run_load("fresp", 32'h100, 2'd2, 1'b0, 4'd10, 32'hDEADBEEF, 1'b0);
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    chk("flush_resp/valid", {31'd0, mem_resp_valid}, 32'd0);
    chk("flush_resp/tag", {28'd0, resp_tag}, {28'd0, INVALID});

    run_load("rst", 32'h100, 2'd2, 1'b0, 4'd9, 32'hDEADBEEF, 1'b0);
    RST = 1'b1; #1;
    chk_reset_outs("rst_resp");
    @(posedge CLK); #1;
    RST = 1'b0;
    run_load("post_rst", 32'h104, 2'd2, 1'b0, 4'd11, 32'h12345678, 1'b0);
    grant_release("post_rst");

`ifdef LOAD_RESP_MISALIGN_CHECK_EN
    run_load("mis_w", 32'h101, 2'd2, 1'b0, 4'd12, 32'h0, 1'b1);
    grant_release("mis_w");
    run_load("mis_h", 32'h101, 2'd1, 1'b0, 4'd13, 32'h0, 1'b1);
    grant_release("mis_h");
    run_load("mis_h3", 32'h103, 2'd1, 1'b1, 4'd14, 32'h0, 1'b1);
    grant_release("mis_h3");
`else
    run_load("mis_w", 32'h101, 2'd2, 1'b0, 4'd12, 32'hDEADBEEF, 1'b0);
    grant_release("mis_w");
    run_load("mis_h", 32'h101, 2'd1, 1'b0, 4'd13, 32'hFFFFBEEF, 1'b0);
    grant_release("mis_h");
    run_load("mis_h3", 32'h103, 2'd1, 1'b1, 4'd14, 32'h0000DEAD, 1'b0);
    grant_release("mis_h3");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
